// File: rtl/dvi_reset_sequencer_if.sv
// Purpose: groups the mmcm_locked input and the sequenced reset/debug outputs of dvi_reset_sequencer.
// Latency: none; this is a plain signal bundle.
// Backpressure: none; all signals are level-based status/reset lines.
interface dvi_reset_sequencer_if;
   logic       mmcm_locked;
   logic       serdes_rst;
   logic       logic_rst_n;
   logic [2:0] seq_state;
   logic [7:0] lock_loss_count;

   // Sequencer side: consumes lock status, drives the resets and debug state.
   modport master (
      input  mmcm_locked,
      output serdes_rst,
      output logic_rst_n,
      output seq_state,
      output lock_loss_count
   );

   // Consumer side: MMCM lock source plus the reset/debug sinks.
   modport slave (
      output mmcm_locked,
      input  serdes_rst,
      input  logic_rst_n,
      input  seq_state,
      input  lock_loss_count
   );
endinterface

// File: rtl/dvi_reset_sequencer.sv
// Purpose: synchronises mmcm_locked into clk_dvi, then releases serdes_rst followed by logic_rst_n.
// Latency: serdes_rst falls SYNC_STAGES+1+LOCK_STABLE_CYCLES+SERDES_RST_CYCLES edges after lock is first sampled.
// Backpressure: none; free-running sequencer, lock loss re-asserts both resets SYNC_STAGES+1 edges later.
module dvi_reset_sequencer #(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int SERDES_RST_CYCLES  = 16,
   parameter int LOGIC_DELAY_CYCLES = 8
) (
   input  logic                    clk_dvi,
   input  logic                    rst_n,
   dvi_reset_sequencer_if.master   rst_if
);

   // The dwell counter only ever needs to reach (longest dwell - 1).
   localparam int MAX_A     = (LOCK_STABLE_CYCLES > SERDES_RST_CYCLES) ? LOCK_STABLE_CYCLES : SERDES_RST_CYCLES;
   localparam int MAX_DWELL = (MAX_A > LOGIC_DELAY_CYCLES) ? MAX_A : LOGIC_DELAY_CYCLES;
   localparam int CNT_W     = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SERDES_LAST = CNT_W'(SERDES_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOGIC_LAST  = CNT_W'(LOGIC_DELAY_CYCLES - 1);

   typedef enum logic [2:0] {
      WAIT_LOCK  = 3'd0,
      STABLE     = 3'd1,
      SERDES_RST = 3'd2,
      LOGIC_RST  = 3'd3,
      RUN        = 3'd4
   } seq_state_t;

   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
   logic             locked_s;

   seq_state_t       state_q;
   seq_state_t       state_nxt;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_nxt;
   logic             serdes_rst_q;
   logic             logic_rst_n_q;
   logic [7:0]       lock_loss_q;
   logic             run_to_wait;

   // Bring the asynchronous MMCM lock flag into clk_dvi through a plain flop chain.
   always_ff @(posedge clk_dvi or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rst_if.mmcm_locked};
      end
   end

   assign locked_s = sync_q[SYNC_STAGES-1];

   // Next-state and dwell counter; lock loss wins over any dwell completing on the same edge.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      if ((state_q != WAIT_LOCK) && !locked_s) begin
         state_nxt = WAIT_LOCK;
         cnt_nxt   = '0;
      end else begin
         case (state_q)
            WAIT_LOCK: begin
               cnt_nxt = '0;
               if (locked_s) begin
                  state_nxt = STABLE;
               end
            end
            STABLE: begin
               if (cnt_q == STABLE_LAST) begin
                  state_nxt = SERDES_RST;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_q + CNT_W'(1);
               end
            end
            SERDES_RST: begin
               if (cnt_q == SERDES_LAST) begin
                  state_nxt = LOGIC_RST;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_q + CNT_W'(1);
               end
            end
            LOGIC_RST: begin
               if (cnt_q == LOGIC_LAST) begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_q + CNT_W'(1);
               end
            end
            RUN: begin
               cnt_nxt = '0;
            end
            default: begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Only a loss from the fully released state counts as a debug event.
   assign run_to_wait = (state_q == RUN) && (state_nxt == WAIT_LOCK);

   // State, counter and outputs all register together so the resets change on the state edge without glitches.
   always_ff @(posedge clk_dvi or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= WAIT_LOCK;
         cnt_q         <= '0;
         serdes_rst_q  <= 1'b1;
         logic_rst_n_q <= 1'b0;
         lock_loss_q   <= 8'd0;
      end else begin
         state_q       <= state_nxt;
         cnt_q         <= cnt_nxt;
         serdes_rst_q  <= (state_nxt == WAIT_LOCK) || (state_nxt == STABLE) || (state_nxt == SERDES_RST);
         logic_rst_n_q <= (state_nxt == RUN);
         if (run_to_wait && (lock_loss_q != 8'hFF)) begin
            lock_loss_q <= lock_loss_q + 8'd1;
         end
      end
   end

   assign rst_if.serdes_rst      = serdes_rst_q;
   assign rst_if.logic_rst_n     = logic_rst_n_q;
   assign rst_if.seq_state       = state_q;
   assign rst_if.lock_loss_count = lock_loss_q;

   // Transmitter logic must never be out of reset while the OSERDES is still held.
   a_release_order : assert property (@(posedge clk_dvi) disable iff (!rst_n)
      rst_if.logic_rst_n |-> !rst_if.serdes_rst);

   // Only the five defined encodings may ever appear on the debug state.
   a_state_legal : assert property (@(posedge clk_dvi) disable iff (!rst_n)
      state_q inside {WAIT_LOCK, STABLE, SERDES_RST, LOGIC_RST, RUN});

endmodule

// File: tb/tb_dvi_reset_sequencer.sv
// Purpose: self-checking bench for dvi_reset_sequencer: vector table, hand sequences, random lock toggling vs a run-length model.
// Latency: checks DUT outputs #1 after each active edge and at every falling edge.
// Backpressure: none; stimulus is the mmcm_locked level and rst_n pulses.
module tb_dvi_reset_sequencer;

   localparam int SYNC   = 2;
   localparam int LOCKC  = 8;
   localparam int SERC   = 4;
   localparam int LOGC   = 2;
   localparam int T_SER  = LOCKC;                // last run length still in STABLE
   localparam int T_LOG  = LOCKC + SERC;         // last run length still in SERDES_RST
   localparam int T_RUN  = LOCKC + SERC + LOGC;  // last run length still in LOGIC_RST

   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   logic model_en = 1'b0;

   dvi_reset_sequencer_if dut_if ();

   dvi_reset_sequencer #(
      .SYNC_STAGES        (SYNC),
      .LOCK_STABLE_CYCLES (LOCKC),
      .SERDES_RST_CYCLES  (SERC),
      .LOGIC_DELAY_CYCLES (LOGC)
   ) dut (
      .clk_dvi (clk),
      .rst_n   (rst_n),
      .rst_if  (dut_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog: the bench drives fixed edge counts, so this only fires on a simulator stall.
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: the sequencer's state is a pure function of how many consecutive
   // edges have seen a synchronised lock; the synchroniser is just an SYNC-edge delay.
   logic [SYNC-1:0] m_pipe;
   int              m_run;
   int              m_cnt;

   function automatic int exp_state(input int r);
      if (r == 0)          return 0;
      else if (r <= T_SER) return 1;
      else if (r <= T_LOG) return 2;
      else if (r <= T_RUN) return 3;
      else                 return 4;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pipe <= '0;
         m_run  <= 0;
         m_cnt  <= 0;
      end else begin
         m_pipe <= {m_pipe[SYNC-2:0], dut_if.mmcm_locked};
         if (m_pipe[SYNC-1]) begin
            m_run <= (m_run < 100000) ? m_run + 1 : m_run;
         end else begin
            m_run <= 0;
            if ((m_run > T_RUN) && (m_cnt < 255)) m_cnt <= m_cnt + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (model_en) begin
         check("model_state",  32'(dut_if.seq_state),       32'(exp_state(m_run)));
         check("model_serdes", 32'(dut_if.serdes_rst),      32'(exp_state(m_run) < 3));
         check("model_logic",  32'(dut_if.logic_rst_n),     32'(exp_state(m_run) == 4));
         check("model_count",  32'(dut_if.lock_loss_count), 32'(m_cnt));
      end
   end

   typedef struct {
      logic locked;
      int   edges;
      int   st;
      logic srst;
      logic lrst_n;
      int   cnt;
   } vec_t;

   vec_t tbl[$];

   initial begin
      // Edge numbers in comments count from the first edge that samples mmcm_locked=1.
      tbl.push_back('{1'b0, 100, 0, 1'b1, 1'b0, 0}); // idle without lock
      tbl.push_back('{1'b1,   2, 0, 1'b1, 1'b0, 0}); // edge 2: still synchronising
      tbl.push_back('{1'b1,   1, 1, 1'b1, 1'b0, 0}); // edge 3: STABLE
      tbl.push_back('{1'b1,   7, 1, 1'b1, 1'b0, 0}); // edge 10: last STABLE
      tbl.push_back('{1'b1,   1, 2, 1'b1, 1'b0, 0}); // edge 11: SERDES_RST
      tbl.push_back('{1'b1,   3, 2, 1'b1, 1'b0, 0}); // edge 14
      tbl.push_back('{1'b1,   1, 3, 1'b0, 1'b0, 0}); // edge 15: serdes_rst falls
      tbl.push_back('{1'b1,   1, 3, 1'b0, 1'b0, 0}); // edge 16
      tbl.push_back('{1'b1,   1, 4, 1'b0, 1'b1, 0}); // edge 17: logic_rst_n rises
      tbl.push_back('{1'b1,  50, 4, 1'b0, 1'b1, 0}); // holds in RUN
      tbl.push_back('{1'b0,   1, 4, 1'b0, 1'b1, 0}); // edge j: loss not yet visible
      tbl.push_back('{1'b0,   1, 4, 1'b0, 1'b1, 0}); // edge j+1
      tbl.push_back('{1'b0,   1, 0, 1'b1, 1'b0, 1}); // edge j+2: both resets back, count 1
      tbl.push_back('{1'b1,   2, 0, 1'b1, 1'b0, 1}); // re-lock edge 2
      tbl.push_back('{1'b1,   1, 1, 1'b1, 1'b0, 1}); // edge 3
      tbl.push_back('{1'b1,  11, 2, 1'b1, 1'b0, 1}); // edge 14
      tbl.push_back('{1'b1,   1, 3, 1'b0, 1'b0, 1}); // edge 15
      tbl.push_back('{1'b1,   1, 3, 1'b0, 1'b0, 1}); // edge 16
      tbl.push_back('{1'b1,   1, 4, 1'b0, 1'b1, 1}); // edge 17

      rst_n              = 1'b0;
      dut_if.mmcm_locked = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_serdes", 32'(dut_if.serdes_rst),      32'd1);
      check("rst_logic",  32'(dut_if.logic_rst_n),     32'd0);
      check("rst_state",  32'(dut_if.seq_state),       32'd0);
      check("rst_count",  32'(dut_if.lock_loss_count), 32'd0);
      model_en = 1'b1;
      #4;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         dut_if.mmcm_locked = tbl[i].locked;
         adv(tbl[i].edges);
         check($sformatf("vec%0d_state", i),  32'(dut_if.seq_state),       32'(tbl[i].st));
         check($sformatf("vec%0d_serdes", i), 32'(dut_if.serdes_rst),      32'(tbl[i].srst));
         check($sformatf("vec%0d_logic", i),  32'(dut_if.logic_rst_n),     32'(tbl[i].lrst_n));
         check($sformatf("vec%0d_count", i),  32'(dut_if.lock_loss_count), 32'(tbl[i].cnt));
      end

      // One-cycle glitch during STABLE: back to WAIT_LOCK, no count, full restart from re-lock.
      dut_if.mmcm_locked = 1'b0;
      adv(4);
      check("glitch_pre_count", 32'(dut_if.lock_loss_count), 32'd2);
      dut_if.mmcm_locked = 1'b1;
      adv(3);
      check("glitch_stable", 32'(dut_if.seq_state), 32'd1);
      adv(3);
      dut_if.mmcm_locked = 1'b0;
      adv(1);
      dut_if.mmcm_locked = 1'b1;
      adv(1);                                   // relative edge 1 after re-lock
      adv(1);
      check("glitch_wait",  32'(dut_if.seq_state),       32'd0);
      check("glitch_count", 32'(dut_if.lock_loss_count), 32'd2);
      adv(12);                                  // relative edge 14
      check("glitch_srst_held", 32'(dut_if.serdes_rst), 32'd1);
      adv(1);
      check("glitch_srst_rel",  32'(dut_if.serdes_rst), 32'd0);
      adv(1);
      check("glitch_lrst_held", 32'(dut_if.logic_rst_n), 32'd0);
      adv(1);
      check("glitch_lrst_rel",  32'(dut_if.logic_rst_n), 32'd1);
      check("glitch_run",       32'(dut_if.seq_state),   32'd4);

      // Many RUN->loss cycles: the counter saturates at 255.
      for (int k = 0; k < 300; k++) begin
         dut_if.mmcm_locked = 1'b0;
         adv(3 + int'($urandom_range(0, 2)));
         dut_if.mmcm_locked = 1'b1;
         adv(17 + int'($urandom_range(0, 3)));
      end
      check("sat_run",   32'(dut_if.seq_state),       32'd4);
      check("sat_count", 32'(dut_if.lock_loss_count), 32'd255);
      dut_if.mmcm_locked = 1'b0;
      adv(4);
      check("sat_hold", 32'(dut_if.lock_loss_count), 32'd255);

      // Asynchronous reset in LOGIC_RST returns to reset values at once, then a full sequence.
      dut_if.mmcm_locked = 1'b1;
      adv(15);
      check("arst_pre_state", 32'(dut_if.seq_state), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_serdes", 32'(dut_if.serdes_rst),      32'd1);
      check("arst_logic",  32'(dut_if.logic_rst_n),     32'd0);
      check("arst_state",  32'(dut_if.seq_state),       32'd0);
      check("arst_count",  32'(dut_if.lock_loss_count), 32'd0);
      #3;
      rst_n = 1'b1;
      adv(1);                                   // edge 1 after release
      adv(13);
      check("arst_srst_held", 32'(dut_if.serdes_rst),  32'd1);
      adv(1);
      check("arst_srst_rel",  32'(dut_if.serdes_rst),  32'd0);
      adv(2);
      check("arst_lrst_rel",  32'(dut_if.logic_rst_n), 32'd1);

      // Random lock toggling with occasional reset pulses; the run-length model checks every cycle.
      for (int seg = 0; seg < 60; seg++) begin
         dut_if.mmcm_locked = ~dut_if.mmcm_locked;
         adv(int'($urandom_range(1, 25)));
         if ($urandom_range(0, 14) == 0) begin
            #2;
            rst_n = 1'b0;
            #3;
            rst_n = 1'b1;
            adv(1);
         end
      end
      adv(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
